pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset wait, run with branch/halt/stall priority, and halt states.
// pc_plus_step is the only combinational output; everything else is registered.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             pc_valid,
    output logic             halted,
    output logic             wrapped
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        RUN      = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t         state;
    logic [WIDTH:0] sum;

    // Extra bit captures the carry-out used for the sticky wrap flag.
    assign sum          = {1'b0, pc} + {1'b0, STEP};
    assign pc_plus_step = sum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RST_WAIT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            case (state)
                RST_WAIT: begin
                    if (branch_valid) begin
                        pc       <= branch_target;
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end else if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (branch_valid) begin
                        pc <= branch_target;
                    end else if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_plus_step;
                        if (sum[WIDTH]) begin
                            wrapped <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (branch_valid) begin
                        pc <= branch_target;
                    end
                    if (resume) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= RST_WAIT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default 32-bit instance and an 8-bit STEP=4 instance.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_stall, a_branch_valid, a_halt_req, a_resume;
    logic [31:0] a_branch_target, a_pc, a_pc_plus_step;
    logic        a_pc_valid, a_halted, a_wrapped;

    logic        b_reset, b_stall, b_branch_valid, b_halt_req, b_resume;
    logic [7:0]  b_branch_target, b_pc, b_pc_plus_step;
    logic        b_pc_valid, b_halted, b_wrapped;

    pc_sequencer dut_a (
        .clk(clk), .reset(a_reset), .stall(a_stall), .branch_valid(a_branch_valid),
        .branch_target(a_branch_target), .halt_req(a_halt_req), .resume(a_resume),
        .pc(a_pc), .pc_plus_step(a_pc_plus_step), .pc_valid(a_pc_valid),
        .halted(a_halted), .wrapped(a_wrapped)
    );

    pc_sequencer #(.WIDTH(8), .STEP(8'd4), .RESET_VECTOR(8'hF8)) dut_b (
        .clk(clk), .reset(b_reset), .stall(b_stall), .branch_valid(b_branch_valid),
        .branch_target(b_branch_target), .halt_req(b_halt_req), .resume(b_resume),
        .pc(b_pc), .pc_plus_step(b_pc_plus_step), .pc_valid(b_pc_valid),
        .halted(b_halted), .wrapped(b_wrapped)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_reset = 1'b0; a_stall = 1'b0; a_branch_valid = 1'b0;
        a_branch_target = '0; a_halt_req = 1'b0; a_resume = 1'b0;
    endtask

    task automatic b_idle();
        b_reset = 1'b0; b_stall = 1'b0; b_branch_valid = 1'b0;
        b_branch_target = '0; b_halt_req = 1'b0; b_resume = 1'b0;
    endtask

    task automatic test_reset();
        a_idle(); b_idle();
        a_reset = 1'b1; a_branch_valid = 1'b1; a_branch_target = 32'h1234; a_halt_req = 1'b1;
        b_reset = 1'b1;
        tick(); tick();
        checks++; if (a_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", a_pc, 32'h0); end
        checks++; if (a_pc_plus_step !== 32'h1) begin errors++; $display("FAIL reset_pcps: got %h exp %h", a_pc_plus_step, 32'h1); end
        checks++; if ({a_pc_valid, a_halted, a_wrapped} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {a_pc_valid, a_halted, a_wrapped}); end
        checks++; if (b_pc !== 8'hF8) begin errors++; $display("FAIL reset_b_pc: got %h exp f8", b_pc); end
        checks++; if (b_pc_plus_step !== 8'hFC) begin errors++; $display("FAIL reset_b_pcps: got %h exp fc", b_pc_plus_step); end
    endtask

    task automatic test_sequential();
        a_idle();
        tick();
        checks++; if (a_pc !== 32'h0 || a_pc_valid !== 1'b1) begin errors++; $display("FAIL first_run: pc %h valid %b exp 0 1", a_pc, a_pc_valid); end
        for (int i = 1; i <= 2000; i++) begin
            tick();
            checks++;
            if (a_pc !== 32'(i) || a_pc_plus_step !== 32'(i + 1) || a_wrapped !== 1'b0 || a_pc_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_step: pc %h pcps %h wr %b exp pc %h pcps %h wr 0", a_pc, a_pc_plus_step, a_wrapped, 32'(i), 32'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        logic       exp_wr [4];
        exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
        exp_wr[0] = 1'b0;  exp_wr[1] = 1'b0;  exp_wr[2] = 1'b1;  exp_wr[3] = 1'b1;
        b_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (b_pc !== exp_pc[i] || b_wrapped !== exp_wr[i]) begin
                errors++;
                $display("FAIL wrap_step%0d: pc %h wr %b exp %h %b", i, b_pc, b_wrapped, exp_pc[i], exp_wr[i]);
            end
        end
        b_branch_valid = 1'b1; b_branch_target = 8'h00;
        tick();
        b_idle();
        checks++; if (b_pc !== 8'h00 || b_wrapped !== 1'b1) begin errors++; $display("FAIL branch_keeps_wrap: pc %h wr %b exp 00 1", b_pc, b_wrapped); end
    endtask

    task automatic test_branch_stall();
        a_idle();
        a_branch_valid = 1'b1; a_branch_target = 32'h10;
        tick();
        a_stall = 1'b1; a_halt_req = 1'b1; a_branch_target = 32'h400;
        tick();
        checks++; if (a_pc !== 32'h400 || a_pc_valid !== 1'b1 || a_halted !== 1'b0) begin errors++; $display("FAIL branch_over_stall: pc %h valid %b halt %b exp 400 1 0", a_pc, a_pc_valid, a_halted); end
        a_idle();
        tick();
        checks++; if (a_pc !== 32'h401) begin errors++; $display("FAIL branch_then_inc: got %h exp 401", a_pc); end
        checks++; if (a_wrapped !== 1'b0) begin errors++; $display("FAIL branch_no_wrap: got %b exp 0", a_wrapped); end
    endtask

    task automatic test_halt();
        a_idle();
        a_branch_valid = 1'b1; a_branch_target = 32'h20;
        tick();
        a_idle(); a_halt_req = 1'b1;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h20 || a_halted !== 1'b1 || a_pc_valid !== 1'b0) begin errors++; $display("FAIL halt_entry: pc %h halt %b valid %b exp 20 1 0", a_pc, a_halted, a_pc_valid); end
        checks++; if (a_pc_plus_step !== 32'h21) begin errors++; $display("FAIL halt_pcps: got %h exp 21", a_pc_plus_step); end
        a_stall = 1'b1; a_halt_req = 1'b1;
        tick(); tick();
        a_idle();
        checks++; if (a_pc !== 32'h20 || a_halted !== 1'b1) begin errors++; $display("FAIL halt_hold: pc %h halt %b exp 20 1", a_pc, a_halted); end
        a_branch_valid = 1'b1; a_branch_target = 32'h80;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h80 || a_halted !== 1'b1 || a_pc_valid !== 1'b0) begin errors++; $display("FAIL halt_branch: pc %h halt %b valid %b exp 80 1 0", a_pc, a_halted, a_pc_valid); end
        a_resume = 1'b1;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h80 || a_halted !== 1'b0 || a_pc_valid !== 1'b1) begin errors++; $display("FAIL resume: pc %h halt %b valid %b exp 80 0 1", a_pc, a_halted, a_pc_valid); end
        tick();
        checks++; if (a_pc !== 32'h81) begin errors++; $display("FAIL resume_inc: got %h exp 81", a_pc); end
        a_halt_req = 1'b1;
        tick();
        a_idle(); a_branch_valid = 1'b1; a_branch_target = 32'h300; a_resume = 1'b1;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h300 || a_halted !== 1'b0 || a_pc_valid !== 1'b1) begin errors++; $display("FAIL branch_resume: pc %h halt %b valid %b exp 300 0 1", a_pc, a_halted, a_pc_valid); end
        tick();
        checks++; if (a_pc !== 32'h301) begin errors++; $display("FAIL branch_resume_inc: got %h exp 301", a_pc); end
    endtask

    task automatic test_reset_halted();
        b_idle(); b_halt_req = 1'b1;
        tick();
        checks++; if (b_halted !== 1'b1 || b_wrapped !== 1'b1) begin errors++; $display("FAIL b_halt: halt %b wr %b exp 1 1", b_halted, b_wrapped); end
        b_idle(); b_reset = 1'b1;
        tick();
        checks++; if (b_pc !== 8'hF8 || {b_pc_valid, b_halted, b_wrapped} !== 3'b000) begin errors++; $display("FAIL reset_from_halt: pc %h flags %b exp f8 000", b_pc, {b_pc_valid, b_halted, b_wrapped}); end
        b_resume = 1'b1; b_halt_req = 1'b1;
        tick();
        checks++; if (b_pc !== 8'hF8 || {b_pc_valid, b_halted, b_wrapped} !== 3'b000) begin errors++; $display("FAIL reset_held: pc %h flags %b exp f8 000", b_pc, {b_pc_valid, b_halted, b_wrapped}); end
        b_idle();
        tick();
        checks++; if (b_pc !== 8'hF8 || b_pc_valid !== 1'b1 || b_halted !== 1'b0) begin errors++; $display("FAIL b_release: pc %h valid %b halt %b exp f8 1 0", b_pc, b_pc_valid, b_halted); end
        tick();
        checks++; if (b_pc !== 8'hFC) begin errors++; $display("FAIL b_release_inc: got %h exp fc", b_pc); end
    endtask

    task automatic test_stall();
        a_idle(); a_branch_valid = 1'b1; a_branch_target = 32'h7;
        tick();
        a_idle(); a_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_pc !== 32'h7 || a_pc_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: pc %h valid %b exp 7 1", i, a_pc, a_pc_valid); end
        end
        a_idle();
        tick();
        checks++; if (a_pc !== 32'h8) begin errors++; $display("FAIL stall_release: got %h exp 8", a_pc); end
    endtask

    task automatic test_rst_wait_paths();
        a_idle(); a_stall = 1'b1; a_reset = 1'b1;
        tick();
        checks++; if (a_pc !== 32'h0 || a_pc_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: pc %h valid %b exp 0 0", a_pc, a_pc_valid); end
        a_idle(); a_branch_valid = 1'b1; a_branch_target = 32'h55; a_halt_req = 1'b1;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h55 || a_pc_valid !== 1'b1 || a_halted !== 1'b0) begin errors++; $display("FAIL rstwait_branch: pc %h valid %b halt %b exp 55 1 0", a_pc, a_pc_valid, a_halted); end
        tick();
        checks++; if (a_pc !== 32'h56) begin errors++; $display("FAIL rstwait_branch_inc: got %h exp 56", a_pc); end
        a_reset = 1'b1;
        tick();
        a_idle(); a_halt_req = 1'b1;
        tick();
        a_idle();
        checks++; if (a_pc !== 32'h0 || a_halted !== 1'b1 || a_pc_valid !== 1'b0) begin errors++; $display("FAIL rstwait_halt: pc %h halt %b valid %b exp 0 1 0", a_pc, a_halted, a_pc_valid); end
        tick();
        checks++; if (a_pc !== 32'h0 || a_halted !== 1'b1) begin errors++; $display("FAIL rstwait_halt_hold: pc %h halt %b exp 0 1", a_pc, a_halted); end
    endtask

    initial begin
        a_idle(); b_idle();
        test_reset();
        test_sequential();
        test_wrap();
        test_branch_stall();
        test_halt();
        test_reset_halted();
        test_stall();
        test_rst_wait_paths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
